// File: rtl/data_mem_responder_if.sv
// Data memory port bundle between the core (master) and the data responder (slave).
interface data_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] data_addr_i;
    logic                  data_we_i;
    logic [1:0]            data_type_i;
    logic [3:0]            data_be_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic [DATA_WIDTH-1:0] rdata_o;

    modport master (
        output data_addr_i,
        output data_we_i,
        output data_type_i,
        output data_be_i,
        output wdata_i,
        input  rdata_o
    );

    modport slave (
        input  data_addr_i,
        input  data_we_i,
        input  data_type_i,
        input  data_be_i,
        input  wdata_i,
        output rdata_o
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-side responder: byte-enabled word RAM, a 16-byte register window
// (tohost, 64-bit cycle counter, sticky error status) and error decode.
// Reads are combinational; all state changes at the rising clock edge.
module data_mem_responder #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus,
    output logic                 tohost_valid_o,
    output logic [31:0]          tohost_data_o,
    output logic                 err_o
);

    localparam int                    IDX_BITS  = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] RAM_LIMIT = ADDR_WIDTH'(4 * DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] MMIO_ADDR = ADDR_WIDTH'(MMIO_BASE);

    typedef enum logic [1:0] {
        ACC_BYTE = 2'b00,
        ACC_HALF = 2'b01,
        ACC_WORD = 2'b10,
        ACC_RSVD = 2'b11
    } acc_t;

    typedef enum logic [1:0] {
        REG_TOHOST   = 2'b00,
        REG_CYCLE_LO = 2'b01,
        REG_CYCLE_HI = 2'b10,
        REG_STATUS   = 2'b11
    } mmio_reg_t;

    logic [31:0]           mem [DEPTH_WORDS];
    logic [63:0]           cycle_q;

    acc_t                  acc;
    mmio_reg_t             reg_sel;
    logic [1:0]            off;
    logic [ADDR_WIDTH-1:0] mmio_off;
    logic [IDX_BITS-1:0]   ram_idx;
    logic [31:0]           ram_word;
    logic [31:0]           ram_shift;
    logic                  ram_hit;
    logic                  mmio_hit;
    logic                  fmt_ok;
    logic                  be_ok;
    logic                  legal;
    logic                  ram_we;
    logic                  mmio_we;
    logic [31:0]           rdata;

    assign acc       = acc_t'(bus.data_type_i);
    assign off       = bus.data_addr_i[1:0];
    // Subtracting the base folds both window bounds into one unsigned compare
    assign mmio_off  = bus.data_addr_i - MMIO_ADDR;
    assign mmio_hit  = (mmio_off < ADDR_WIDTH'(16));
    assign reg_sel   = mmio_reg_t'(mmio_off[3:2]);
    assign ram_hit   = (bus.data_addr_i < RAM_LIMIT);
    assign ram_idx   = bus.data_addr_i[IDX_BITS+1:2];
    assign ram_word  = mem[ram_idx];
    assign ram_shift = ram_word >> {off, 3'b000};

    // Legality: type/alignment always, byte enables only on writes, window is word-only
    always_comb begin
        fmt_ok = 1'b0;
        be_ok  = 1'b0;
        case (acc)
            ACC_BYTE: begin
                fmt_ok = 1'b1;
                be_ok  = (bus.data_be_i == (4'b0001 << off));
            end
            ACC_HALF: begin
                fmt_ok = ~off[0];
                be_ok  = (bus.data_be_i == (4'b0011 << off));
            end
            ACC_WORD: begin
                fmt_ok = (off == 2'd0);
                be_ok  = (bus.data_be_i == 4'hF);
            end
            default: begin
                fmt_ok = 1'b0;
                be_ok  = 1'b0;
            end
        endcase
        legal = fmt_ok && (!bus.data_we_i || be_ok) &&
                (ram_hit || (mmio_hit && acc == ACC_WORD));
    end

    assign ram_we  = bus.data_we_i && legal && ram_hit;
    assign mmio_we = bus.data_we_i && legal && !ram_hit;

    // Combinational read path, right-aligned and zero-extended; 0 on any illegal access
    always_comb begin
        rdata = '0;
        if (legal) begin
            if (ram_hit) begin
                case (acc)
                    ACC_BYTE: rdata = {24'b0, ram_shift[7:0]};
                    ACC_HALF: rdata = {16'b0, ram_shift[15:0]};
                    default:  rdata = ram_word;
                endcase
            end else begin
                case (reg_sel)
                    REG_TOHOST:   rdata = tohost_data_o;
                    REG_CYCLE_LO: rdata = cycle_q[31:0];
                    REG_CYCLE_HI: rdata = cycle_q[63:32];
                    default:      rdata = {31'b0, err_o};
                endcase
            end
        end
    end

    assign bus.rdata_o = DATA_WIDTH'(rdata);

    // RAM lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (bus.data_be_i[i]) begin
                    mem[ram_idx][8*i +: 8] <= bus.wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Window registers: cycle counter, tohost pulse/data, sticky error (set beats clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q        <= '0;
            tohost_valid_o <= 1'b0;
            tohost_data_o  <= '0;
            err_o          <= 1'b0;
        end else begin
            cycle_q        <= cycle_q + 64'd1;
            tohost_valid_o <= mmio_we && (reg_sel == REG_TOHOST);
            if (mmio_we && (reg_sel == REG_TOHOST)) begin
                tohost_data_o <= bus.wdata_i[31:0];
            end
            if (!legal) begin
                err_o <= 1'b1;
            end else if (mmio_we && (reg_sel == REG_STATUS) && bus.wdata_i[0]) begin
                err_o <= 1'b0;
            end
        end
    end

endmodule
